i2c_slave_eeprom: RTL and testbench
===================================

// Module: i2c_slave_eeprom
// PURPOSE
//  Synthesizable I2C target that emulates a 24LCxx-style EEPROM: 7-bit device address,
//  2-byte word address, sequential write and read with auto-increment. Sits on the
//  board-side i2c_scl/i2c_sda lines opposite the i2c_eeprom master. Replaces the
//  behavioural M24LC64 model in loopback tests and serves as an on-FPGA I2C peripheral.
//  Oversamples SCL/SDA on sys_clk; no clock is derived from SCL.
// PARAMETERS
//  DEV_ADDR   7'b1010_000  7-bit target address; R/W is bit 0 of the first byte.
//  ADDR_W     8            implemented word-address bits; memory depth = 2**ADDR_W bytes.
// PORTS
//  sys_clk    in   1       system clock, 50 MHz; SCL <= 400 kHz.
//  sys_rst    in   1       asynchronous reset, active-high.
//  scl_in     in   1       SCL pin level (asynchronous).
//  sda_in     in   1       SDA pin level (asynchronous).
//  sda_oe     out  1       1 = pull SDA low; 0 = release. Top level: i2c_sda = sda_oe ? 1'b0 : 1'bz.
//  busy       out  1       1 while state != IDLE.
// BEHAVIOUR
//  Reset: sda_oe=0, busy=0, state=IDLE, word pointer=0, bit counter=0.
//   Memory contents are not cleared by reset.
//  Sync: scl_in and sda_in each pass through 2 flops, plus one flop for edge detection.
//   scl_rise and scl_fall are single-cycle pulses.
//  START: sda falls while scl is high. Accepted in any state (repeated START included).
//   Goes to DEV; clears bit counter; releases sda_oe.
//  STOP: sda rises while scl is high. Accepted in any state. Goes to IDLE; sda_oe=0.
//  Bit timing:
//   - SDA is sampled on scl_rise, MSB first.
//   - sda_oe changes only on scl_fall, so it never changes while SCL is high.
//  ACK slot: 8th scl_rise of a received byte -> the next scl_fall sets sda_oe=1.
//   The following scl_fall (end of the 9th clock) releases it, or drives the next read bit.
//  States:
//   IDLE      -> DEV on START.
//   DEV       shift 8 bits. Byte[7:1]==DEV_ADDR -> ACK, then:
//             R/W=0 -> AHI; R/W=1 -> RD.
//             Mismatch -> no ACK -> WAIT_STOP.
//   AHI       receive high address byte, ACK -> ALO.
//   ALO       receive low address byte, ACK. ptr = {hi,lo}[ADDR_W-1:0]. -> WR.
//   WR        receive data byte. On 8th scl_rise: mem[ptr] <= byte; ptr <= ptr+1. ACK.
//             Stay in WR. Repeated START here gives a random read via DEV.
//   RD        on the scl_fall that ends the ACK slot, load mem[ptr] and drive sda_oe = ~bit7.
//             Each later scl_fall shifts out the next bit. After bit0's scl_fall, release SDA.
//             9th scl_rise samples the master ACK:
//               sda=0 -> ptr+1, next byte;
//               sda=1 (NACK) -> ptr+1 -> WAIT_STOP.
//   WAIT_STOP sda_oe=0; ignore SCL; leave only on START or STOP.
//  Pointer wraps modulo 2**ADDR_W. Word-address bits above ADDR_W are ignored.
//  No page boundary and no write-cycle busy time; ACK is always given when addressed.
//  The pointer persists across transactions, so a current-address read
//   (START, DEV|R) continues from the last ptr.
//  Simultaneous cases:
//   - START/STOP detection takes priority over bit sampling in the same cycle.
//   - sys_rst mid-transfer aborts immediately and releases SDA. The bus recovers at the next START.
// TESTING
//  1 Write: S A0 00 10 55 AA P -> 5 ACKs (sda_oe=1 in each 9th clock); mem[10h]=55h, mem[11h]=AAh.
//  2 Random read: S A0 00 10 Sr A1, master ACK then NACK, P -> bytes 55h, AAh on SDA;
//    sda_oe=0 after NACK; busy=0 after P.
//  3 Address mismatch: S A2 ... -> sda_oe stays 0 through the 9th clock and all later clocks
//    until P; memory unchanged.
//  4 Wrap: S A0 00 FF 11 22 P, then random read at FFh for 2 bytes -> 11h, 22h
//    (second byte read from 00h).
//  5 Current-address read: after test 1, S A1 with NACK, P -> returns mem[12h]; ptr becomes 13h.
//  6 Reset mid-byte: pulse sys_rst during bit 4 of a WR data byte -> sda_oe=0 and busy=0
//    at once; byte not written; next full write/read sequence passes.

Source files
------------

// File: rtl/i2c_slave_eeprom.sv
// i2c_slave_eeprom: I2C target emulating a 24LCxx-style EEPROM.
// The block has a 7-bit device address, a 2-byte word address, and sequential
// write/read with auto-increment. SCL and SDA are oversampled on sys_clk, and
// SDA is driven open-drain through sda_oe.
module i2c_slave_eeprom #(
    parameter logic [6:0] DEV_ADDR = 7'b1010_000,
    parameter int         ADDR_W   = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_oe,
    output logic busy
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEV       = 3'd1,
        ST_AHI       = 3'd2,
        ST_ALO       = 3'd3,
        ST_WR        = 3'd4,
        ST_RD        = 3'd5,
        ST_WAIT_STOP = 3'd6
    } state_t;

    localparam int                DEPTH   = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              scl_meta_r, scl_sync_r, scl_prev_r;
    logic              sda_meta_r, sda_sync_r, sda_prev_r;
    state_t            state_r, state_nxt_s;
    logic [3:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]        shift_r, shift_nxt_s;
    logic [7:0]        hi_r, hi_nxt_s;
    logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
    logic              sda_oe_r, sda_oe_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              mem_we_s;
    logic [7:0]        mem_r [DEPTH];
    logic              scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]        rx_byte_s, mem_rdata_s;

    // Two-flop synchronisers plus one history flop for edge/condition detection
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_meta_r <= 1'b0;
            scl_sync_r <= 1'b0;
            scl_prev_r <= 1'b0;
            sda_meta_r <= 1'b0;
            sda_sync_r <= 1'b0;
            sda_prev_r <= 1'b0;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // SCL edges are one-cycle pulses; START/STOP need SCL stable high
    always_comb begin
        scl_rise_s  = scl_sync_r & ~scl_prev_r;
        scl_fall_s  = ~scl_sync_r & scl_prev_r;
        start_s     = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
        stop_s      = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
        rx_byte_s   = {shift_r[6:0], sda_sync_r};
        mem_rdata_s = mem_r[ptr_r];
    end

    // Protocol next-state, datapath and SDA drive decode
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        hi_nxt_s      = hi_r;
        ptr_nxt_s     = ptr_r;
        sda_oe_nxt_s  = sda_oe_r;
        mem_we_s      = 1'b0;
        if (start_s) begin
            state_nxt_s   = ST_DEV;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
        end else if (stop_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_DEV, ST_AHI, ST_ALO, ST_WR: begin
                    // bit_cnt: 0..7 data bits, 8 = byte complete, 9 = ACK clock high
                    if (scl_rise_s) begin
                        if (bit_cnt_r < 4'd8) begin
                            shift_nxt_s   = rx_byte_s;
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        end else begin
                            bit_cnt_nxt_s = 4'd9;
                        end
                        if (bit_cnt_r == 4'd7) begin
                            case (state_r)
                                ST_DEV: begin
                                    if (rx_byte_s[7:1] == DEV_ADDR) begin
                                        state_nxt_s = ST_DEV;
                                    end else begin
                                        state_nxt_s   = ST_WAIT_STOP;
                                        bit_cnt_nxt_s = 4'd0;
                                    end
                                end
                                ST_AHI:  hi_nxt_s = rx_byte_s;
                                ST_ALO:  ptr_nxt_s = ADDR_W'({hi_r, rx_byte_s});
                                ST_WR: begin
                                    mem_we_s  = 1'b1;
                                    ptr_nxt_s = ptr_r + PTR_ONE;
                                end
                                default: mem_we_s = 1'b0;
                            endcase
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_nxt_s = 1'b1;
                        end else if (bit_cnt_r == 4'd9) begin
                            bit_cnt_nxt_s = 4'd0;
                            sda_oe_nxt_s  = 1'b0;
                            case (state_r)
                                ST_DEV: begin
                                    if (shift_r[0]) begin
                                        state_nxt_s  = ST_RD;
                                        shift_nxt_s  = mem_rdata_s;
                                        sda_oe_nxt_s = ~mem_rdata_s[7];
                                    end else begin
                                        state_nxt_s = ST_AHI;
                                    end
                                end
                                ST_AHI:  state_nxt_s = ST_ALO;
                                ST_ALO:  state_nxt_s = ST_WR;
                                default: state_nxt_s = ST_WR;
                            endcase
                        end else begin
                            sda_oe_nxt_s = sda_oe_r;
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_RD: begin
                    // Master samples on rise; we shift on rise and drive the new MSB on fall
                    if (scl_rise_s) begin
                        if (bit_cnt_r < 4'd8) begin
                            shift_nxt_s   = {shift_r[6:0], 1'b0};
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        end else begin
                            ptr_nxt_s = ptr_r + PTR_ONE;
                            if (sda_sync_r) begin
                                state_nxt_s   = ST_WAIT_STOP;
                                bit_cnt_nxt_s = 4'd0;
                            end else begin
                                bit_cnt_nxt_s = 4'd9;
                            end
                        end
                    end else if (scl_fall_s) begin
                        case (bit_cnt_r)
                            4'd0: sda_oe_nxt_s = sda_oe_r;
                            4'd8: sda_oe_nxt_s = 1'b0;
                            4'd9: begin
                                shift_nxt_s   = mem_rdata_s;
                                sda_oe_nxt_s  = ~mem_rdata_s[7];
                                bit_cnt_nxt_s = 4'd0;
                            end
                            default: sda_oe_nxt_s = ~shift_r[7];
                        endcase
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                default: begin
                    sda_oe_nxt_s  = 1'b0;
                    bit_cnt_nxt_s = 4'd0;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Protocol state and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            hi_r      <= 8'h00;
            ptr_r     <= {ADDR_W{1'b0}};
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            hi_r      <= hi_nxt_s;
            ptr_r     <= ptr_nxt_s;
            sda_oe_r  <= sda_oe_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Byte storage; contents deliberately survive reset
    always_ff @(posedge sys_clk) begin
        if (mem_we_s) begin
            mem_r[ptr_r] <= rx_byte_s;
        end
    end

    assign sda_oe = sda_oe_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Directed + randomized bench for i2c_slave_eeprom. A bit-banged master drives
// the bus, and a byte-array model of the EEPROM supplies the expected values.
module tb_i2c_slave_eeprom;
    localparam int Q = 6;   // sys_clk cycles per quarter SCL period

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic scl_m   = 1'b1;
    logic sda_m   = 1'b1;
    logic sda_oe;
    logic busy;
    logic sda_bus;

    assign sda_bus = sda_m & ~sda_oe;   // open-drain wired-AND with pull-up

    i2c_slave_eeprom #(.DEV_ADDR(7'b1010_000), .ADDR_W(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [256];
    int         ref_ptr  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // One SCL clock; returns bus level just after the rise and just before the fall
    task automatic bit_cycle(input logic b, output logic s_early, output logic s_late);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(1);
        s_early = sda_bus;
        tick(2*Q-2);
        s_late = sda_bus;
        tick(1);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic se, sl;
        logic [7:0] be, bl;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(d[i], se, sl);
            be[i] = se;
            bl[i] = sl;
        end
        check({tag, "_bits_early"}, be, d);
        check({tag, "_bits_late"}, bl, d);
        bit_cycle(1'b1, se, sl);
        check({tag, "_ack_early"}, !se, exp_ack);
        check({tag, "_ack_late"}, !sl, exp_ack);
    endtask

    task automatic recv_byte(input logic ack_m, input logic [7:0] exp, input string tag);
        logic se, sl, mb;
        logic [7:0] be, bl;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, se, sl);
            be[i] = se;
            bl[i] = sl;
        end
        check({tag, "_early"}, be, exp);
        check({tag, "_late"}, bl, exp);
        mb = ack_m ? 1'b0 : 1'b1;
        bit_cycle(mb, se, sl);
        check({tag, "_ackslot_release"}, sl, mb);
    endtask

    task automatic write_txn(input logic [15:0] a, input logic [7:0] data [$]);
        i2c_start();
        check("busy_in_txn", busy, 1'b1);
        send_byte(8'hA0, 1'b1, "wr_dev");
        send_byte(a[15:8], 1'b1, "wr_ahi");
        send_byte(a[7:0], 1'b1, "wr_alo");
        ref_ptr = a[7:0];
        foreach (data[i]) begin
            send_byte(data[i], 1'b1, "wr_data");
            ref_mem[ref_ptr] = data[i];
            ref_ptr = (ref_ptr + 1) % 256;
        end
        i2c_stop();
        check("busy_after_wr_stop", busy, 1'b0);
    endtask

    // START/Sr, device read address, n bytes (ACK all but the last), STOP
    task automatic read_body(input int n);
        i2c_start();
        send_byte(8'hA1, 1'b1, "rd_dev");
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n-1, ref_mem[ref_ptr], "rd_data");
            ref_ptr = (ref_ptr + 1) % 256;
        end
        i2c_stop();
        check("busy_after_rd_stop", busy, 1'b0);
    endtask

    task automatic read_rand(input logic [15:0] a, input int n);
        i2c_start();
        send_byte(8'hA0, 1'b1, "rr_dev");
        send_byte(a[15:8], 1'b1, "rr_ahi");
        send_byte(a[7:0], 1'b1, "rr_alo");
        ref_ptr = a[7:0];
        read_body(n);
    endtask

    initial begin
        logic [7:0]  q [$];
        logic [15:0] a;
        int          len;
        logic        se, sl;

        tick(4);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        sys_rst = 1'b0;
        tick(4);
        check("idle_sda_oe", sda_oe, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Preload locations that later current-address and reset tests read
        q.delete(); q.push_back(8'($urandom)); q.push_back(8'($urandom));
        write_txn(16'h0012, q);
        q.delete(); q.push_back(8'($urandom));
        write_txn(16'h0030, q);

        // Sequential write at 10h
        q.delete(); q.push_back(8'h55); q.push_back(8'hAA);
        write_txn(16'h0010, q);

        // Current-address reads continue at 12h, then 13h
        read_body(1);
        read_body(1);

        // Wrong device address: never acknowledged, nothing written
        i2c_start();
        send_byte(8'hA2, 1'b0, "mm_dev");
        send_byte(8'h00, 1'b0, "mm_ahi");
        send_byte(8'h10, 1'b0, "mm_alo");
        send_byte(8'h77, 1'b0, "mm_data");
        check("mm_busy_wait_stop", busy, 1'b1);
        i2c_stop();
        check("mm_busy_after_stop", busy, 1'b0);

        // Random read of 10h..11h (checks the mismatch left memory intact)
        read_rand(16'h0010, 2);

        // Pointer wrap from FFh to 00h
        q.delete(); q.push_back(8'h11); q.push_back(8'h22);
        write_txn(16'h00FF, q);
        read_rand(16'h00FF, 2);

        // Reset during bit 4 of a write data byte (F5h)
        i2c_start();
        send_byte(8'hA0, 1'b1, "rst_dev");
        send_byte(8'h00, 1'b1, "rst_ahi");
        send_byte(8'h30, 1'b1, "rst_alo");
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, se, sl);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check("rst_mid_busy_before", busy, 1'b1);
        sys_rst = 1'b1;
        #1;
        check("rst_mid_sda_oe", sda_oe, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        tick(2);
        sys_rst = 1'b0;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        i2c_stop();
        ref_ptr = 0;
        read_body(1);                 // pointer restarted at 00h
        read_rand(16'h0030, 1);       // aborted byte was not stored
        q.delete(); q.push_back(8'($urandom));
        write_txn(16'h0030, q);
        read_rand(16'h0030, 1);

        // Randomized writes with read-back; upper word-address byte is random
        repeat (8) begin
            a   = 16'($urandom);
            len = $urandom_range(1, 4);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            write_txn(a, q);
            read_rand({8'($urandom), a[7:0]}, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
